tia_hcount: RTL and testbench

// - TIA horizontal sync counter.
// - Divides the colour clock by 4 into one-cycle phase strobes phi1 and phi2.
// - Steps a 6-bit polynomial (LFSR) counter through 57 states per 228-clock line.
// - Decodes counter states into one-cycle set/reset strobes and the HSYNC, HBLANK
//   and colour-burst levels. These feed the playfield, object-counter and sync

---
 rtl/tia_hcount_pkg.sv | 41 ++++
 rtl/tia_hcount_if.sv | 30 +++
 rtl/tia_hc_decode.sv | 53 +++++
 rtl/tia_hcount_core.sv | 90 +++++++++
 rtl/tia_hcount.sv | 63 ++++++
 tb/tb_tia_hcount.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/tia_hcount_pkg.sv
// Shared widths, LFSR helpers and decode constants for the TIA horizontal counter.
// Decode constants are derived from the polynomial at elaboration time.
package tia_hc_pkg;

    localparam int unsigned HC_W         = 6;
    localparam int unsigned DIV_W        = 2;
    localparam int unsigned HC_STEPS_DEF = 57;

    function automatic logic [HC_W-1:0] hc_next(input logic [HC_W-1:0] s);
        return {s[4:0], ~(s[5] ^ s[4])};
    endfunction

    // LFSR value reached after idx steps from the all-zero state
    function automatic logic [HC_W-1:0] hc_at(input int unsigned idx);
        logic [HC_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < idx; i++) begin
            s = hc_next(s);
        end
        return s;
    endfunction

    localparam logic [HC_W-1:0] HC_SHB  = hc_at(0);
    localparam logic [HC_W-1:0] HC_SHS  = hc_at(4);
    localparam logic [HC_W-1:0] HC_RHS  = hc_at(8);
    localparam logic [HC_W-1:0] HC_RCB  = hc_at(12);
    localparam logic [HC_W-1:0] HC_RHB  = hc_at(16);
    localparam logic [HC_W-1:0] HC_LRHB = hc_at(18);
    localparam logic [HC_W-1:0] HC_CNT  = hc_at(36);
    localparam logic [HC_W-1:0] HC_END  = hc_at(HC_STEPS_DEF - 1);

    typedef struct packed {
        logic shb;
        logic shs;
        logic rhs;
        logic rcb;
        logic rhb;
        logic cnt;
    } hc_strobe_t;

endpackage

// File: rtl/tia_hcount_if.sv
// Control inputs and decoded sync outputs of the horizontal counter.
interface tia_hcount_if;
    import tia_hc_pkg::*;

    logic            rsync;
    logic            hmove_latch;
    logic            phi1;
    logic            phi2;
    logic [HC_W-1:0] hcount;
    logic            shb;
    logic            rhs;
    logic            rcb;
    logic            shs;
    logic            rhb;
    logic            cnt;
    logic            hsync;
    logic            hblank;
    logic            cburst;

    modport master (
        output rsync, hmove_latch,
        input  phi1, phi2, hcount, shb, rhs, rcb, shs, rhb, cnt, hsync, hblank, cburst
    );

    modport slave (
        input  rsync, hmove_latch,
        output phi1, phi2, hcount, shb, rhs, rcb, shs, rhb, cnt, hsync, hblank, cburst
    );

endinterface

// File: rtl/tia_hc_decode.sv
// Compares the held counter state in its first phase, so each strobe is high while div==1.
module tia_hc_decode
    import tia_hc_pkg::*;
#(
    parameter bit LATE_HB_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rsync,
    input  logic             hmove_latch,
    input  logic [DIV_W-1:0] div_q,
    input  logic [HC_W-1:0]  lfsr_q,
    output hc_strobe_t       stb_q
);

    hc_strobe_t stb_d;
    logic       late_q;
    logic       late_d;
    logic       early_rhb;

    always_comb begin
        stb_d     = '0;
        late_d    = late_q;
        early_rhb = !(LATE_HB_EN && hmove_latch);

        if (div_q == DIV_W'(0)) begin
            stb_d.shb = (lfsr_q == HC_SHB);
            stb_d.shs = (lfsr_q == HC_SHS);
            stb_d.rhs = (lfsr_q == HC_RHS);
            stb_d.rcb = (lfsr_q == HC_RCB);
            stb_d.cnt = (lfsr_q == HC_CNT);
            stb_d.rhb = ((lfsr_q == HC_RHB) && early_rhb) || ((lfsr_q == HC_LRHB) && late_q);
            // HMOVE choice is frozen at the early decode point for the rest of the line
            if (lfsr_q == HC_RHB) begin
                late_d = !early_rhb;
            end
        end
        if (rsync) begin
            stb_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stb_q  <= '0;
            late_q <= 1'b0;
        end else begin
            stb_q  <= stb_d;
            late_q <= late_d;
        end
    end

endmodule

// File: rtl/tia_hcount_core.sv
// Colour-clock divider, 57-state LFSR line counter and the set/reset level registers.
module tia_hcount_core
    import tia_hc_pkg::*;
#(
    parameter int unsigned HC_STEPS = HC_STEPS_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rsync,
    input  logic             shb,
    input  logic             shs,
    input  logic             rhs,
    input  logic             rcb,
    input  logic             rhb,
    output logic [DIV_W-1:0] div_q,
    output logic [HC_W-1:0]  lfsr_q,
    output logic             phi1_q,
    output logic             phi2_q,
    output logic             hsync_q,
    output logic             hblank_q,
    output logic             cburst_q
);

    localparam logic [HC_W-1:0] HC_LAST = hc_at(HC_STEPS - 1);

    logic [DIV_W-1:0] div_d;
    logic [HC_W-1:0]  lfsr_d;
    logic             phi1_d;
    logic             phi2_d;
    logic             hsync_d;
    logic             hblank_d;
    logic             cburst_d;

    always_comb begin
        div_d    = div_q + DIV_W'(1);
        lfsr_d   = lfsr_q;
        hsync_d  = hsync_q;
        hblank_d = hblank_q;
        cburst_d = cburst_q;

        // counter steps once per four colour clocks; the last state loads zero
        if (div_q == DIV_W'(3)) begin
            lfsr_d = (lfsr_q == HC_LAST) ? '0 : hc_next(lfsr_q);
        end
        if (rsync) begin
            div_d  = '0;
            lfsr_d = '0;
        end

        phi1_d = (div_d == DIV_W'(0));
        phi2_d = (div_d == DIV_W'(2));

        if (shs) begin
            hsync_d = 1'b1;
        end else if (rhs) begin
            hsync_d = 1'b0;
        end
        if (shb) begin
            hblank_d = 1'b1;
        end else if (rhb) begin
            hblank_d = 1'b0;
        end
        if (rhs) begin
            cburst_d = 1'b1;
        end else if (rcb) begin
            cburst_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            lfsr_q   <= '0;
            phi1_q   <= 1'b0;
            phi2_q   <= 1'b0;
            hsync_q  <= 1'b0;
            hblank_q <= 1'b1;
            cburst_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            lfsr_q   <= lfsr_d;
            phi1_q   <= phi1_d;
            phi2_q   <= phi2_d;
            hsync_q  <= hsync_d;
            hblank_q <= hblank_d;
            cburst_q <= cburst_d;
        end
    end

endmodule

// File: rtl/tia_hcount.sv
// TIA horizontal sync counter: phase strobes, LFSR line position and HSYNC/HBLANK/burst decode.
module tia_hcount
    import tia_hc_pkg::*;
#(
    parameter int unsigned HC_STEPS   = HC_STEPS_DEF,
    parameter bit          LATE_HB_EN = 1'b1
) (
    input  logic         clock,
    input  logic         reset,
    tia_hcount_if.slave  bus
);

    logic [DIV_W-1:0] div_q;
    logic [HC_W-1:0]  lfsr_q;
    hc_strobe_t       stb_q;
    logic             phi1_q;
    logic             phi2_q;
    logic             hsync_q;
    logic             hblank_q;
    logic             cburst_q;

    tia_hcount_core #(.HC_STEPS(HC_STEPS)) u_core (
        .clock    (clock),
        .reset    (reset),
        .rsync    (bus.rsync),
        .shb      (stb_q.shb),
        .shs      (stb_q.shs),
        .rhs      (stb_q.rhs),
        .rcb      (stb_q.rcb),
        .rhb      (stb_q.rhb),
        .div_q    (div_q),
        .lfsr_q   (lfsr_q),
        .phi1_q   (phi1_q),
        .phi2_q   (phi2_q),
        .hsync_q  (hsync_q),
        .hblank_q (hblank_q),
        .cburst_q (cburst_q)
    );

    tia_hc_decode #(.LATE_HB_EN(LATE_HB_EN)) u_decode (
        .clock       (clock),
        .reset       (reset),
        .rsync       (bus.rsync),
        .hmove_latch (bus.hmove_latch),
        .div_q       (div_q),
        .lfsr_q      (lfsr_q),
        .stb_q       (stb_q)
    );

    assign bus.phi1   = phi1_q;
    assign bus.phi2   = phi2_q;
    assign bus.hcount = lfsr_q;
    assign bus.shb    = stb_q.shb;
    assign bus.shs    = stb_q.shs;
    assign bus.rhs    = stb_q.rhs;
    assign bus.rcb    = stb_q.rcb;
    assign bus.rhb    = stb_q.rhb;
    assign bus.cnt    = stb_q.cnt;
    assign bus.hsync  = hsync_q;
    assign bus.hblank = hblank_q;
    assign bus.cburst = cburst_q;

endmodule

// File: tb/tb_tia_hcount.sv
// Directed bench for tia_hcount: line timeline, HMOVE late blank, wrap, RSYNC and async reset.
module tb_tia_hcount;

    localparam int LINE = 228;

    logic clock = 1'b0;
    logic reset;

    tia_hcount_if bus ();
    tia_hcount_if bus0 ();

    tia_hcount #(.HC_STEPS(57), .LATE_HB_EN(1'b1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    tia_hcount #(.HC_STEPS(57), .LATE_HB_EN(1'b0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    assign bus0.rsync       = bus.rsync;
    assign bus0.hmove_latch = bus.hmove_latch;

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc;
    int         org;
    bit         fresh;
    bit         late;
    logic [5:0] tab [57];
    logic       e_hsync, e_hblank, e_cburst, e_hblank0;
    logic       p_shb, p_shs, p_rhs, p_rcb, p_rhb, p_rhb0;
    int         n_phi1, n_phi2, n_shb, n_rep;
    logic [5:0] hist [LINE];

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk6(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    // expected outputs for the current cycle from the line timeline
    task automatic check_cycle();
        int   rel, idx, ph;
        logic s_shb, s_shs, s_rhs, s_rcb, s_rhb, s_rhb0, s_cnt;
        if (p_shb) e_hblank = 1'b1; else if (p_rhb) e_hblank = 1'b0;
        if (p_shb) e_hblank0 = 1'b1; else if (p_rhb0) e_hblank0 = 1'b0;
        if (p_shs) e_hsync = 1'b1; else if (p_rhs) e_hsync = 1'b0;
        if (p_rhs) e_cburst = 1'b1; else if (p_rcb) e_cburst = 1'b0;
        rel    = (cyc - org) % LINE;
        idx    = rel / 4;
        ph     = rel % 4;
        s_shb  = (ph == 1) && (idx == 0);
        s_shs  = (ph == 1) && (idx == 4);
        s_rhs  = (ph == 1) && (idx == 8);
        s_rcb  = (ph == 1) && (idx == 12);
        s_rhb  = (ph == 1) && (idx == (late ? 18 : 16));
        s_rhb0 = (ph == 1) && (idx == 16);
        s_cnt  = (ph == 1) && (idx == 36);
        chk1("phi1", bus.phi1, (ph == 0) && !fresh);
        chk1("phi2", bus.phi2, ph == 2);
        chk6("hcount", bus.hcount, tab[idx]);
        chk1("shb", bus.shb, s_shb);
        chk1("shs", bus.shs, s_shs);
        chk1("rhs", bus.rhs, s_rhs);
        chk1("rcb", bus.rcb, s_rcb);
        chk1("rhb", bus.rhb, s_rhb);
        chk1("cnt", bus.cnt, s_cnt);
        chk1("hsync", bus.hsync, e_hsync);
        chk1("hblank", bus.hblank, e_hblank);
        chk1("cburst", bus.cburst, e_cburst);
        chk1("rhb_early_only", bus0.rhb, s_rhb0);
        chk1("hblank_early_only", bus0.hblank, e_hblank0);
        p_shb  = s_shb;
        p_shs  = s_shs;
        p_rhs  = s_rhs;
        p_rcb  = s_rcb;
        p_rhb  = s_rhb;
        p_rhb0 = s_rhb0;
    endtask

    task automatic step(input logic rs);
        bus.rsync = rs;
        @(posedge clock);
        @(negedge clock);
        bus.rsync = 1'b0;
        cyc++;
        fresh = 1'b0;
        if (rs) org = cyc;
        check_cycle();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1'b0);
    endtask

    task automatic do_reset(input logic hm);
        reset           = 1'b0;
        bus.rsync       = 1'b0;
        bus.hmove_latch = hm;
        late            = hm;
        repeat (3) @(negedge clock);
        chk1("rst_hblank", bus.hblank, 1'b1);
        chk1("rst_phi1", bus.phi1, 1'b0);
        chk1("rst_hsync", bus.hsync, 1'b0);
        chk6("rst_hcount", bus.hcount, 6'b000000);
        reset    = 1'b1;
        cyc      = 0;
        org      = 0;
        fresh    = 1'b1;
        e_hblank = 1'b1; e_hblank0 = 1'b1; e_hsync = 1'b0; e_cburst = 1'b0;
        p_shb = 1'b0; p_shs = 1'b0; p_rhs = 1'b0; p_rcb = 1'b0; p_rhb = 1'b0; p_rhb0 = 1'b0;
        check_cycle();
    endtask

    initial begin
        tab[0] = 6'b000000;
        for (int i = 1; i < 57; i++) tab[i] = {tab[i-1][4:0], ~(tab[i-1][5] ^ tab[i-1][4])};

        // free-running line after reset
        do_reset(1'b0);
        run_to(1);   chk1("t_shb1", bus.shb, 1'b1);
        run_to(16);  chk6("t_hc4", bus.hcount, 6'b001111);
        run_to(17);  chk1("t_shs17", bus.shs, 1'b1);
        run_to(18);  chk1("t_hsync18", bus.hsync, 1'b1);
        run_to(20);  chk6("t_hc5", bus.hcount, 6'b011111);
        run_to(33);  chk1("t_rhs33", bus.rhs, 1'b1);
        run_to(34);  chk1("t_hsync34", bus.hsync, 1'b0); chk1("t_cb34", bus.cburst, 1'b1);
        run_to(50);  chk1("t_cb50", bus.cburst, 1'b0);
        run_to(65);  chk1("t_rhb65", bus.rhb, 1'b1);
        run_to(66);  chk1("t_hb66", bus.hblank, 1'b0);
        run_to(145); chk1("t_cnt145", bus.cnt, 1'b1);
        run_to(228); chk6("t_wrap", bus.hcount, 6'b000000);
        run_to(229); chk1("t_shb229", bus.shb, 1'b1);

        // HMOVE late blank end; early-only instance ignores it
        do_reset(1'b1);
        run_to(65);  chk1("hm_rhb65", bus.rhb, 1'b0); chk1("hm0_rhb65", bus0.rhb, 1'b1);
        run_to(66);  chk1("hm_hb66", bus.hblank, 1'b1); chk1("hm0_hb66", bus0.hblank, 1'b0);
        run_to(73);  chk1("hm_rhb73", bus.rhb, 1'b1);
        run_to(74);  chk1("hm_hb74", bus.hblank, 1'b0);
        run_to(LINE + 80);

        // ten lines: periodicity and phase duty
        do_reset(1'b0);
        n_phi1 = 0; n_phi2 = 0; n_shb = 0; n_rep = 0;
        hist[0] = bus.hcount;
        while (cyc < 10 * LINE) begin
            step(1'b0);
            if (bus.phi1) n_phi1++;
            if (bus.phi2) n_phi2++;
            if (bus.shb) n_shb++;
            if (cyc < LINE) hist[cyc] = bus.hcount;
            else if (bus.hcount !== hist[cyc % LINE]) n_rep++;
        end
        chki("phi1_duty", n_phi1, 570);
        chki("phi2_duty", n_phi2, 570);
        chki("shb_per_10_lines", n_shb, 10);
        chki("hcount_repeat", n_rep, 0);

        // RSYNC mid-line, on the wrap edge, and held
        do_reset(1'b0);
        run_to(100);
        step(1'b1);  chk6("rs_hc101", bus.hcount, 6'b000000); chk1("rs_phi1_101", bus.phi1, 1'b1);
        step(1'b0);  chk1("rs_shb102", bus.shb, 1'b1);
        run_to(118); chk1("rs_hsync118", bus.hsync, 1'b0);
        run_to(119); chk1("rs_hsync119", bus.hsync, 1'b1);
        run_to(328);
        step(1'b1);  chk1("rsw_shb329", bus.shb, 1'b0);
        step(1'b0);  chk1("rsw_shb330", bus.shb, 1'b1);
        step(1'b0);  chk1("rsw_shb331", bus.shb, 1'b0);
        run_to(400);
        step(1'b1); step(1'b1); step(1'b1);
        chk6("rsh_hc", bus.hcount, 6'b000000); chk1("rsh_phi1", bus.phi1, 1'b1);
        run_to(420); chk1("rsh_hsync420", bus.hsync, 1'b0);
        run_to(421); chk1("rsh_hsync421", bus.hsync, 1'b1);
        run_to(700);

        // asynchronous reset between edges mid-line
        do_reset(1'b0);
        run_to(70);
        #2 reset = 1'b0;
        #1;
        chk1("ar_hblank", bus.hblank, 1'b1);
        chk1("ar_phi2", bus.phi2, 1'b0);
        chk6("ar_hcount", bus.hcount, 6'b000000);
        chk1("ar_hsync", bus.hsync, 1'b0);
        do_reset(1'b0);
        run_to(17);  chk1("ar_shs17", bus.shs, 1'b1);
        run_to(LINE + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
